dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- Data-memory access stage between the MEM-stage load/store request and the load extractor.
- Accepts one load/store per request, checks alignment, and drives a word-addressed memory bus with byte enables and lane-replicated store data.
- Waits for bus acknowledge while stalling the pipeline.
- For loads, delivers the raw 32-bit read word with the registered address low bits and LSOp, so the downstream extractor selects and sign-extends the byte/half.

Parameters:
ADDR_W, 32, byte-address width of req_addr and bus_addr

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  MEM stage presents a load/store
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_lsop  in  2  11 word, 10 half, 01 byte, 00 treated as word
req_wdata  in  32  store data, right-justified
req_ready  out  1  unit idle and able to accept
stall  out  1  freeze pipeline upstream of MEM
bus_req  out  1  memory request, held until ack
bus_we  out  1  bus write strobe
bus_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
bus_be  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  memory completes current request
bus_rdata  in  32  read word, valid when bus_ack=1
rsp_valid  out  1  one-cycle pulse: load data available
rsp_rdata  out  32  raw read word to extractor
rsp_addr_lo  out  2  req_addr[1:0] of the completed load
rsp_lsop  out  2  req_lsop of the completed load
misalign  out  1  one-cycle pulse: access rejected as misaligned

Behaviour:
- Reset (async, immediate): state IDLE. bus_req, bus_we, rsp_valid and misalign = 0. bus_addr, bus_be, bus_wdata, rsp_rdata, rsp_addr_lo and rsp_lsop = 0. req_ready = 1, stall = 0 until req_valid.
- FSM states IDLE, BUS, DONE. req_ready = (state==IDLE). stall = (state==BUS) | (state==IDLE & req_valid).
- IDLE, req_valid=1: accept. Register addr_lo, lsop, we, and compute bus fields.
  - Misaligned = (lsop==10 & addr[0]) | (lsop in {11,00} & addr[1:0]!=0). Misaligned goes to DONE with misalign=1 and no bus access.
  - Otherwise goes to BUS with bus_req=1 from the next cycle.
- Store fields:
  - Byte: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - Word: be = 1111, wdata unchanged.
- Load fields: be = 1111, bus_we = 0, bus_wdata = 0.
- BUS: bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable.
  - On bus_ack=1 (including the first BUS cycle), a load captures bus_rdata into rsp_rdata. Then go to DONE and deassert bus_req next cycle.
  - bus_ack=0 keeps the unit in BUS indefinitely; there is no timeout.
- DONE, exactly one cycle:
  - rsp_valid = 1 if load & aligned. misalign = 1 if rejected.
  - stall = 0, so the pipeline advances at the end of this cycle. req_ready = 0, so there is no acceptance in DONE. Next state IDLE.
- rsp_rdata, rsp_addr_lo and rsp_lsop hold their values after DONE until the next load completes. rsp_addr_lo and rsp_lsop update together with rsp_rdata.
- Latency, aligned access, ack in first BUS cycle: accept at T, bus_req at T+1, DONE/rsp_valid at T+2. Each extra wait cycle adds 1.
- Latency, misaligned access: DONE at T+1.
- bus_ack while not in BUS: ignored.
- req_valid dropping during BUS: the transaction still completes.
- Reset in BUS: bus_req drops asynchronously, the transaction is abandoned, and no rsp_valid or misalign is produced.

Test Plan:
1. Byte store: addr=0x1003, wdata=0x000000AB, ack in first BUS cycle -> bus_addr=0x1000, be=1000, bus_wdata=0xABABABAB, bus_we=1; stall high 2 cycles; no rsp_valid.
2. Half load: addr=0x2002, lsop=10, bus_rdata=0x8001_1234, ack after 3 wait cycles -> be=1111, bus_we=0; rsp_valid at T+5 with rsp_rdata=0x80011234, rsp_addr_lo=10, rsp_lsop=10.
3. Misaligned word load: addr=0x3001, lsop=11 -> misalign pulse at T+1, bus_req never high, stall high 1 cycle only.
4. Half store: addr=0x4002, wdata=0x0000BEEF -> be=1100, bus_wdata=0xBEEFBEEF. Half store at addr 0x4001 -> misalign, no bus activity.
5. Reset in BUS: rst asserted after 2 wait cycles -> bus_req=0 in the same cycle, req_ready=1. A spurious bus_ack after reset produces no rsp_valid.
6. Back-to-back loads with req_valid held: second request accepted only in the IDLE cycle after DONE. The first load's rsp_rdata holds until the second load's DONE.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
// Signal bundle between the MEM stage, the data-memory access unit, the
// memory bus and the load extractor. The "slave" modport is the access
// unit's view; "master" is the view of the surrounding pipeline/memory.
interface dmem_access_unit_if #(
  parameter int ADDR_W = 32
);
  // MEM-stage request side
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_lsop;
  logic [31:0]       req_wdata;
  logic              req_ready;
  logic              stall;

  // Word-addressed memory bus
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  // Load response towards the extractor
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_addr_lo;
  logic [1:0]        rsp_lsop;
  logic              misalign;

  modport slave (
    input  req_valid, req_we, req_addr, req_lsop, req_wdata,
    output req_ready, stall,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata,
    output rsp_valid, rsp_rdata, rsp_addr_lo, rsp_lsop, misalign
  );

  modport master (
    output req_valid, req_we, req_addr, req_lsop, req_wdata,
    input  req_ready, stall,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata,
    input  rsp_valid, rsp_rdata, rsp_addr_lo, rsp_lsop, misalign
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: takes one load/store from the MEM stage, rejects
// misaligned accesses, drives a word-addressed bus with byte enables and
// lane-replicated store data, stalls the pipeline until acknowledge, and
// hands the raw read word plus address low bits and LSOp to the extractor.
module dmem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_access_unit_if.slave     io
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Size encodings: 11 word, 10 half, 01 byte, 00 behaves as word.
  localparam logic [1:0] LSOP_BYTE = 2'b01;
  localparam logic [1:0] LSOP_HALF = 2'b10;

  // An access is misaligned when its natural alignment is violated.
  function automatic logic is_misaligned(input logic [1:0] lsop, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (lsop)
      LSOP_BYTE: bad = 1'b0;
      LSOP_HALF: bad = lo[0];
      default:   bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

  // Byte enables for a store of the given size at the given lane.
  function automatic logic [3:0] store_be(input logic [1:0] lsop, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b1111;
    case (lsop)
      LSOP_BYTE: be = 4'b0001 << lo;
      LSOP_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across every lane it may land in.
  function automatic logic [31:0] store_wdata(input logic [1:0] lsop, input logic [31:0] wd);
    logic [31:0] rep;
    rep = wd;
    case (lsop)
      LSOP_BYTE: rep = {4{wd[7:0]}};
      LSOP_HALF: rep = {2{wd[15:0]}};
      default:   rep = wd;
    endcase
    return rep;
  endfunction

  state_e            state_q,       state_d;
  logic              we_q,          we_d;
  logic [1:0]        addr_lo_q,     addr_lo_d;
  logic [1:0]        lsop_q,        lsop_d;
  logic              bus_req_q,     bus_req_d;
  logic              bus_we_q,      bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q,    bus_addr_d;
  logic [3:0]        bus_be_q,      bus_be_d;
  logic [31:0]       bus_wdata_q,   bus_wdata_d;
  logic              rsp_valid_q,   rsp_valid_d;
  logic [31:0]       rsp_rdata_q,   rsp_rdata_d;
  logic [1:0]        rsp_addr_lo_q, rsp_addr_lo_d;
  logic [1:0]        rsp_lsop_q,    rsp_lsop_d;
  logic              misalign_q,    misalign_d;

  // Next-state and registered-output computation for the access FSM.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_lo_d     = addr_lo_q;
    lsop_d        = lsop_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_addr_lo_d = rsp_addr_lo_q;
    rsp_lsop_d    = rsp_lsop_q;
    misalign_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (io.req_valid) begin
          we_d      = io.req_we;
          addr_lo_d = io.req_addr[1:0];
          lsop_d    = io.req_lsop;
          if (is_misaligned(io.req_lsop, io.req_addr[1:0])) begin
            // Rejected: skip the bus entirely and report in DONE.
            misalign_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            bus_req_d  = 1'b1;
            bus_we_d   = io.req_we;
            bus_addr_d = {io.req_addr[ADDR_W-1:2], 2'b00};
            if (io.req_we) begin
              bus_be_d    = store_be(io.req_lsop, io.req_addr[1:0]);
              bus_wdata_d = store_wdata(io.req_lsop, io.req_wdata);
            end else begin
              bus_be_d    = 4'b1111;
              bus_wdata_d = 32'h0000_0000;
            end
            state_d = ST_BUS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUS: begin
        if (io.bus_ack) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = ST_DONE;
          if (!we_q) begin
            // Response fields move together so the extractor sees a consistent set.
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = io.bus_rdata;
            rsp_addr_lo_d = addr_lo_q;
            rsp_lsop_d    = lsop_q;
          end else begin
            rsp_valid_d = 1'b0;
          end
        end else begin
          state_d = ST_BUS;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any bus transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      addr_lo_q     <= 2'b00;
      lsop_q        <= 2'b00;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_be_q      <= 4'b0000;
      bus_wdata_q   <= 32'h0000_0000;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0000_0000;
      rsp_addr_lo_q <= 2'b00;
      rsp_lsop_q    <= 2'b00;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      addr_lo_q     <= addr_lo_d;
      lsop_q        <= lsop_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_addr_lo_q <= rsp_addr_lo_d;
      rsp_lsop_q    <= rsp_lsop_d;
      misalign_q    <= misalign_d;
    end
  end

  // Handshake outputs are decoded from the state register; stall also
  // covers the acceptance cycle so the upstream stage holds its request.
  assign io.req_ready   = (state_q == ST_IDLE);
  assign io.stall       = (state_q == ST_BUS) | ((state_q == ST_IDLE) & io.req_valid);

  assign io.bus_req     = bus_req_q;
  assign io.bus_we      = bus_we_q;
  assign io.bus_addr    = bus_addr_q;
  assign io.bus_be      = bus_be_q;
  assign io.bus_wdata   = bus_wdata_q;
  assign io.rsp_valid   = rsp_valid_q;
  assign io.rsp_rdata   = rsp_rdata_q;
  assign io.rsp_addr_lo = rsp_addr_lo_q;
  assign io.rsp_lsop    = rsp_lsop_q;
  assign io.misalign    = misalign_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit.
module tb_dmem_access_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dmem_access_unit_if #(.ADDR_W(32)) bus_if ();

  dmem_access_unit #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [1:0] lsop, input logic [31:0] wdata);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = we;
    bus_if.req_addr  = addr;
    bus_if.req_lsop  = lsop;
    bus_if.req_wdata = wdata;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = 32'h0;
    bus_if.req_lsop  = 2'b00;
    bus_if.req_wdata = 32'h0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;

    // Reset state
    tick();
    tick();
    check_eq("rst_bus_req",   {63'd0, bus_if.bus_req},   64'd0);
    check_eq("rst_req_ready", {63'd0, bus_if.req_ready}, 64'd1);
    check_eq("rst_stall",     {63'd0, bus_if.stall},     64'd0);
    check_eq("rst_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
    check_eq("rst_misalign",  {63'd0, bus_if.misalign},  64'd0);
    check_eq("rst_bus_addr",  {32'd0, bus_if.bus_addr},  64'd0);
    check_eq("rst_bus_be",    {60'd0, bus_if.bus_be},    64'd0);
    check_eq("rst_rsp_rdata", {32'd0, bus_if.rsp_rdata}, 64'd0);
    rst = 1'b0;
    tick();

    // 1. Byte store at 0x1003, ack present already (ignored in IDLE)
    drive_req(1'b1, 32'h0000_1003, 2'b01, 32'h0000_00AB);
    bus_if.bus_ack = 1'b1;
    #1;
    check_eq("t1_stall_accept", {63'd0, bus_if.stall}, 64'd1);
    check_eq("t1_ready_accept", {63'd0, bus_if.req_ready}, 64'd1);
    tick();
    bus_if.req_valid = 1'b0;
    #1;
    check_eq("t1_bus_req",   {63'd0, bus_if.bus_req},   64'd1);
    check_eq("t1_bus_we",    {63'd0, bus_if.bus_we},    64'd1);
    check_eq("t1_bus_addr",  {32'd0, bus_if.bus_addr},  64'h1000);
    check_eq("t1_bus_be",    {60'd0, bus_if.bus_be},    64'b1000);
    check_eq("t1_bus_wdata", {32'd0, bus_if.bus_wdata}, 64'hABABABAB);
    check_eq("t1_stall_bus", {63'd0, bus_if.stall},     64'd1);
    check_eq("t1_ready_bus", {63'd0, bus_if.req_ready}, 64'd0);
    tick();
    bus_if.bus_ack = 1'b0;
    #1;
    check_eq("t1_done_bus_req", {63'd0, bus_if.bus_req},   64'd0);
    check_eq("t1_done_rsp",     {63'd0, bus_if.rsp_valid}, 64'd0);
    check_eq("t1_done_stall",   {63'd0, bus_if.stall},     64'd0);
    check_eq("t1_done_ready",   {63'd0, bus_if.req_ready}, 64'd0);
    check_eq("t1_done_misal",   {63'd0, bus_if.misalign},  64'd0);
    tick();
    check_eq("t1_idle_ready",   {63'd0, bus_if.req_ready}, 64'd1);

    // 2. Half load at 0x2002, three wait cycles
    drive_req(1'b0, 32'h0000_2002, 2'b10, 32'h0);
    tick();
    bus_if.req_valid = 1'b0;
    #1;
    check_eq("t2_bus_req",   {63'd0, bus_if.bus_req},   64'd1);
    check_eq("t2_bus_we",    {63'd0, bus_if.bus_we},    64'd0);
    check_eq("t2_bus_be",    {60'd0, bus_if.bus_be},    64'hF);
    check_eq("t2_bus_addr",  {32'd0, bus_if.bus_addr},  64'h2000);
    check_eq("t2_bus_wdata", {32'd0, bus_if.bus_wdata}, 64'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("t2_wait_req",   {63'd0, bus_if.bus_req},   64'd1);
      check_eq("t2_wait_stall", {63'd0, bus_if.stall},     64'd1);
      check_eq("t2_wait_rsp",   {63'd0, bus_if.rsp_valid}, 64'd0);
    end
    tick();
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h8001_1234;
    tick();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("t2_rsp_valid",   {63'd0, bus_if.rsp_valid},   64'd1);
    check_eq("t2_rsp_rdata",   {32'd0, bus_if.rsp_rdata},   64'h80011234);
    check_eq("t2_rsp_addr_lo", {62'd0, bus_if.rsp_addr_lo}, 64'd2);
    check_eq("t2_rsp_lsop",    {62'd0, bus_if.rsp_lsop},    64'd2);
    check_eq("t2_done_stall",  {63'd0, bus_if.stall},       64'd0);
    tick();
    check_eq("t2_rsp_pulse",   {63'd0, bus_if.rsp_valid},   64'd0);
    check_eq("t2_rsp_hold",    {32'd0, bus_if.rsp_rdata},   64'h80011234);

    // 3. Misaligned word load at 0x3001
    drive_req(1'b0, 32'h0000_3001, 2'b11, 32'h0);
    #1;
    check_eq("t3_stall_accept", {63'd0, bus_if.stall}, 64'd1);
    tick();
    bus_if.req_valid = 1'b0;
    #1;
    check_eq("t3_misalign", {63'd0, bus_if.misalign},  64'd1);
    check_eq("t3_bus_req",  {63'd0, bus_if.bus_req},   64'd0);
    check_eq("t3_stall",    {63'd0, bus_if.stall},     64'd0);
    check_eq("t3_rsp",      {63'd0, bus_if.rsp_valid}, 64'd0);
    tick();
    check_eq("t3_misal_pulse", {63'd0, bus_if.misalign}, 64'd0);
    check_eq("t3_bus_req2",    {63'd0, bus_if.bus_req},  64'd0);
    check_eq("t3_ready",       {63'd0, bus_if.req_ready}, 64'd1);

    // 4a. Half store at 0x4002
    drive_req(1'b1, 32'h0000_4002, 2'b10, 32'h0000_BEEF);
    tick();
    bus_if.req_valid = 1'b0;
    bus_if.bus_ack   = 1'b1;
    #1;
    check_eq("t4_bus_be",    {60'd0, bus_if.bus_be},    64'b1100);
    check_eq("t4_bus_wdata", {32'd0, bus_if.bus_wdata}, 64'hBEEFBEEF);
    check_eq("t4_bus_addr",  {32'd0, bus_if.bus_addr},  64'h4000);
    tick();
    bus_if.bus_ack = 1'b0;
    #1;
    check_eq("t4_no_rsp", {63'd0, bus_if.rsp_valid}, 64'd0);
    tick();
    // 4b. Half store at 0x4001 is misaligned
    drive_req(1'b1, 32'h0000_4001, 2'b10, 32'h0000_BEEF);
    tick();
    bus_if.req_valid = 1'b0;
    #1;
    check_eq("t4_misalign", {63'd0, bus_if.misalign}, 64'd1);
    check_eq("t4_mis_bus",  {63'd0, bus_if.bus_req},  64'd0);
    tick();

    // 5. Reset during BUS after two wait cycles
    drive_req(1'b0, 32'h0000_5000, 2'b11, 32'h0);
    tick();
    bus_if.req_valid = 1'b0;
    tick();
    tick();
    check_eq("t5_before_rst", {63'd0, bus_if.bus_req}, 64'd1);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_bus_req", {63'd0, bus_if.bus_req},   64'd0);
    check_eq("t5_rst_ready",   {63'd0, bus_if.req_ready}, 64'd1);
    check_eq("t5_rst_stall",   {63'd0, bus_if.stall},     64'd0);
    check_eq("t5_rst_rdata",   {32'd0, bus_if.rsp_rdata}, 64'd0);
    tick();
    rst = 1'b0;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t5_spurious_rsp", {63'd0, bus_if.rsp_valid}, 64'd0);
      check_eq("t5_spurious_mis", {63'd0, bus_if.misalign},  64'd0);
      check_eq("t5_spurious_req", {63'd0, bus_if.bus_req},   64'd0);
    end
    bus_if.bus_ack = 1'b0;
    tick();

    // 6. Back-to-back loads with req_valid held high
    drive_req(1'b0, 32'h0000_6004, 2'b11, 32'h0);
    tick();
    drive_req(1'b0, 32'h0000_6009, 2'b01, 32'h0);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h1111_1111;
    #1;
    check_eq("t6_a_addr",  {32'd0, bus_if.bus_addr},  64'h6004);
    check_eq("t6_a_ready", {63'd0, bus_if.req_ready}, 64'd0);
    tick();
    bus_if.bus_ack = 1'b0;
    #1;
    check_eq("t6_a_rsp",     {63'd0, bus_if.rsp_valid},   64'd1);
    check_eq("t6_a_rdata",   {32'd0, bus_if.rsp_rdata},   64'h11111111);
    check_eq("t6_a_lsop",    {62'd0, bus_if.rsp_lsop},    64'd3);
    check_eq("t6_a_addr_lo", {62'd0, bus_if.rsp_addr_lo}, 64'd0);
    check_eq("t6_done_ready",{63'd0, bus_if.req_ready},   64'd0);
    check_eq("t6_done_breq", {63'd0, bus_if.bus_req},     64'd0);
    tick();
    check_eq("t6_idle_ready", {63'd0, bus_if.req_ready}, 64'd1);
    check_eq("t6_idle_stall", {63'd0, bus_if.stall},     64'd1);
    check_eq("t6_idle_breq",  {63'd0, bus_if.bus_req},   64'd0);
    tick();
    bus_if.req_valid = 1'b0;
    #1;
    check_eq("t6_b_breq",  {63'd0, bus_if.bus_req},   64'd1);
    check_eq("t6_b_addr",  {32'd0, bus_if.bus_addr},  64'h6008);
    check_eq("t6_b_hold1", {32'd0, bus_if.rsp_rdata}, 64'h11111111);
    tick();
    check_eq("t6_b_hold2", {32'd0, bus_if.rsp_rdata}, 64'h11111111);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h2222_2222;
    tick();
    bus_if.bus_ack = 1'b0;
    #1;
    check_eq("t6_b_rsp",     {63'd0, bus_if.rsp_valid},   64'd1);
    check_eq("t6_b_rdata",   {32'd0, bus_if.rsp_rdata},   64'h22222222);
    check_eq("t6_b_addr_lo", {62'd0, bus_if.rsp_addr_lo}, 64'd1);
    check_eq("t6_b_lsop",    {62'd0, bus_if.rsp_lsop},    64'd1);
    tick();
    check_eq("t6_end_rsp",   {63'd0, bus_if.rsp_valid},   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
